pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised successor to the fixed-field ID/EXE latch: a generic pipeline-stage register carrying an opaque payload and a separate control-bit vector between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It adds valid/ready flow control (stall), synchronous flush with bubble insertion, and an optional skid entry that registers `in_ready`. Control bits such as RF_enable, load_instr and S are forced to zero whenever the slot is empty, so downstream logic never acts on a bubble. A saturating bubble counter supports performance measurement.

## Interface
- `DATA_W`, 32: payload width (operands, immediate, register numbers), never masked.
- `CTRL_W`, 8: control-vector width, zeroed on bubble/flush/reset.
- `SKID`, 1: 0 = single entry with combinational `in_ready`; 1 = main plus skid entry with registered `in_ready`.
- `CNT_W`, 16: bubble counter width.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has an entry.
- `in_ready`  out  1  stage accepts this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control bits.
- `out_valid`  out  1  entry presented downstream.
- `out_ready`  in  1  downstream accepts (low = stall).
- `out_data`  out  DATA_W  presented payload.
- `out_ctrl`  out  CTRL_W  presented control, equals 0 when `out_valid`=0.
- `flush`  in  1  synchronous discard of all held entries.
- `cnt_clr`  in  1  synchronous clear of `bubble_cnt`.
- `bubble_cnt`  out  CNT_W  saturating count of bubble cycles.

## Operation
- Accept: `in_valid && in_ready`. Emit: `out_valid && out_ready`.
- Main entry (M) drives the outputs. Skid entry (K) exists only when SKID=1.
- SKID=0:
  - `in_ready = !flush && (!M.valid || out_ready)`.
  - On accept, M loads the input.
  - On emit without accept, M.valid clears.
- SKID=1:
  - `in_ready = !flush && !K.valid`. The `!K.valid` term is registered.
  - If K is valid and an emit occurs, K moves to M and K clears. An input accepted in the same cycle loads K.
  - If K is empty, accept loads M when M is empty or emitting. Otherwise accept loads K.
  - K is never valid while M is empty.
- Flush takes priority over all other events. Next state: M.valid=0, K.valid=0, no accept.
  - An emit in the flush cycle still completes downstream.
  - Payload registers keep their old values.
- `out_ctrl = M.ctrl & {CTRL_W{M.valid}}`. `out_data = M.data`, unmasked.
- `bubble_cnt` increments by 1 in each cycle with `out_ready && !out_valid`. It saturates at 2^CNT_W−1.
  - `cnt_clr` sets it to 0 and takes priority over an increment in the same cycle.

## Timing
- Reset values:
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `bubble_cnt`=0.
  - K cleared.
  - `in_ready`=1 (SKID=1) or 1 (SKID=0, since `!M.valid`) while `flush`=0.
- Reset is asynchronous. Asserting it mid-transfer drops all entries immediately.
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 entry/cycle with `out_ready` held high, for both SKID values.
- SKID=1 stall: 2 entries are absorbed. `in_ready` falls the cycle after K fills, and rises the cycle after K drains.
- Ordering is strict FIFO. No entry is duplicated or lost except by flush or reset.
- Flush and a full M+K in the same cycle: both entries are discarded. `out_valid`=0 on the next cycle.

## Test plan
- Streaming:
  - Stimulus: reset, then 8 entries `in_data`=0x100..0x107, `in_ctrl`=0xA5, with `out_ready`=1 throughout.
  - Response: `out_data` shows 0x100..0x107 on consecutive cycles, 1 cycle after each accept. `bubble_cnt`=1, from the first empty cycle after reset release.
- Stall with SKID=1:
  - Stimulus: stream with `out_ready`=0 for 4 cycles.
  - Response: exactly 2 entries are accepted, `in_ready`=0 from the 3rd cycle, and output holds the first entry. After `out_ready`=1, entries emerge in order with no loss.
- Flush mid-stall:
  - Stimulus: M and K full, `flush`=1 for 1 cycle.
  - Response: next cycle `out_valid`=0, `out_ctrl`=0, and `out_data` keeps its stale value. The input presented during the flush cycle is not accepted.
- Bubble masking:
  - Stimulus: `in_valid`=0 with `in_ctrl`=0xFF held on the input.
  - Response: `out_ctrl`=0x00 every cycle. `bubble_cnt` increments only on cycles with `out_ready`=1.
- Counter:
  - With CNT_W=4 and 20 bubble cycles, `bubble_cnt` saturates at 15.
  - `cnt_clr` together with a bubble gives 0 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert `reset_n`=0 asynchronously between clock edges with M+K full.
  - Response: `out_valid` and `out_ctrl` go to 0 immediately, before the next edge. Run the same check with SKID=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: opaque payload plus control vector,
// valid/ready flow control, synchronous flush, optional skid entry that
// registers in_ready, and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Main entry: always the one presented downstream
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready;
    assign emit   = m_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              k_valid;
            logic [DATA_W-1:0] k_data;
            logic [CTRL_W-1:0] k_ctrl;

            // Ready depends only on a register (plus flush), breaking the
            // combinational out_ready -> in_ready path
            assign in_ready = !flush && !k_valid;

            // Main/skid entry update; K always drains into M before new data
            // reaches M so ordering stays FIFO
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    m_ctrl  <= '0;
                    k_valid <= 1'b0;
                    k_data  <= '0;
                    k_ctrl  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    k_valid <= 1'b0;
                end else if (k_valid) begin
                    if (emit) begin
                        m_valid <= 1'b1;
                        m_data  <= k_data;
                        m_ctrl  <= k_ctrl;
                        k_valid <= accept;
                        if (accept) begin
                            k_data <= in_data;
                            k_ctrl <= in_ctrl;
                        end
                    end
                end else if (accept) begin
                    if (!m_valid || emit) begin
                        m_valid <= 1'b1;
                        m_data  <= in_data;
                        m_ctrl  <= in_ctrl;
                    end else begin
                        k_valid <= 1'b1;
                        k_data  <= in_data;
                        k_ctrl  <= in_ctrl;
                    end
                end else if (emit) begin
                    m_valid <= 1'b0;
                end
            end
        end else begin : g_single
            assign in_ready = !flush && (!m_valid || out_ready);

            // Single entry update: load on accept, empty on emit-only
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    m_ctrl  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                end else if (accept) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                    m_ctrl  <= in_ctrl;
                end else if (emit) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};

    // Saturating count of cycles where downstream was ready but got nothing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (out_ready && !m_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: three instances share
// stimulus (SKID=1, SKID=0, SKID=1 with a 4-bit counter); each phase checks
// the instance(s) whose behaviour it targets.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;
    logic        flush;
    logic        cnt_clr;

    logic        r1_in_ready, r1_out_valid;
    logic [31:0] r1_out_data;
    logic [7:0]  r1_out_ctrl;
    logic [15:0] r1_cnt;

    logic        r0_in_ready, r0_out_valid;
    logic [31:0] r0_out_data;
    logic [7:0]  r0_out_ctrl;
    logic [15:0] r0_cnt;

    logic        rc_in_ready, rc_out_valid;
    logic [31:0] rc_out_data;
    logic [7:0]  rc_out_ctrl;
    logic [3:0]  rc_cnt;

    int unsigned checks;
    int unsigned failures;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r1_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(r1_out_valid),
        .out_ready(out_ready), .out_data(r1_out_data), .out_ctrl(r1_out_ctrl),
        .flush(flush), .cnt_clr(cnt_clr), .bubble_cnt(r1_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r0_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(r0_out_valid),
        .out_ready(out_ready), .out_data(r0_out_data), .out_ctrl(r0_out_ctrl),
        .flush(flush), .cnt_clr(cnt_clr), .bubble_cnt(r0_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) dutc (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rc_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(rc_out_valid),
        .out_ready(out_ready), .out_data(rc_out_data), .out_ctrl(rc_out_ctrl),
        .flush(flush), .cnt_clr(cnt_clr), .bubble_cnt(rc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_mask_cnt [5];
    logic        mask_ready   [5];
    logic        stall_ready  [4];
    logic        rdy;
    int unsigned idx;

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = 8'hA5;
        out_ready = 1'b1;
        flush     = 1'b0;
        cnt_clr   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(r1_out_valid), 32'd0);
        check("rst_out_ctrl",  32'(r1_out_ctrl),  32'd0);
        check("rst_out_data",  r1_out_data,       32'd0);
        check("rst_cnt",       32'(r1_cnt),       32'd0);
        check("rst_in_ready1", 32'(r1_in_ready),  32'd1);
        check("rst_in_ready0", 32'(r0_in_ready),  32'd1);

        // Streaming: 8 entries back to back, first edge after release is a bubble
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            #1;
            check("stream_in_ready1", 32'(r1_in_ready), 32'd1);
            check("stream_in_ready0", 32'(r0_in_ready), 32'd1);
            tick();
            check("stream_data1",  r1_out_data,        32'h100 + 32'(i));
            check("stream_data0",  r0_out_data,        32'h100 + 32'(i));
            check("stream_valid1", 32'(r1_out_valid),  32'd1);
            check("stream_ctrl1",  32'(r1_out_ctrl),   32'hA5);
            check("stream_cnt1",   32'(r1_cnt),        32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", 32'(r1_out_valid), 32'd0);
        check("stream_end_ctrl",  32'(r1_out_ctrl),  32'd0);
        check("stream_end_cnt",   32'(r1_cnt),       32'd1);
        check("stream_end_cnt0",  32'(r0_cnt),       32'd1);

        // Bubble masking with all-ones control on the idle input
        in_ctrl = 8'hFF;
        mask_ready   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_mask_cnt = '{32'd2, 32'd2, 32'd3, 32'd4, 32'd4};
        for (int i = 0; i < 5; i++) begin
            out_ready = mask_ready[i];
            tick();
            check("mask_ctrl1", 32'(r1_out_ctrl), 32'd0);
            check("mask_ctrl0", 32'(r0_out_ctrl), 32'd0);
            check("mask_cnt1",  32'(r1_cnt),      exp_mask_cnt[i]);
        end

        // Counter saturation on the 4-bit instance
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt4",  32'(rc_cnt), 32'd15);
        check("sat_cnt16", 32'(r1_cnt), 32'd24);
        cnt_clr = 1'b1;
        tick();
        check("clr_cnt4",  32'(rc_cnt), 32'd0);
        check("clr_cnt16", 32'(r1_cnt), 32'd0);
        cnt_clr = 1'b0;
        tick();
        check("post_clr_cnt4", 32'(rc_cnt), 32'd1);

        // Stall with skid: two entries absorbed, ready drops on the 3rd cycle
        in_ctrl     = 8'hA5;
        idx         = 0;
        stall_ready = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int j = 0; j < 4; j++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 32'h200 + 32'(idx);
            #1;
            rdy = r1_in_ready;
            check("stall_in_ready", 32'(rdy), 32'(stall_ready[j]));
            tick();
            if (rdy) idx++;
            check("stall_hold_data",  r1_out_data,       32'h200);
            check("stall_hold_valid", 32'(r1_out_valid), 32'd1);
        end
        check("stall_accepted", 32'(idx), 32'd2);
        for (int e = 1; e <= 3; e++) begin
            out_ready = 1'b1;
            in_data   = 32'h200 + 32'(idx);
            #1;
            rdy = r1_in_ready;
            tick();
            if (rdy) idx++;
            check("resume_data",  r1_out_data,       32'h200 + 32'(e));
            check("resume_valid", 32'(r1_out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("drain_valid", 32'(r1_out_valid), 32'd0);

        // Flush with M and K both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h300;
        tick();
        in_data = 32'h301;
        tick();
        check("pre_flush_in_ready", 32'(r1_in_ready), 32'd0);
        check("pre_flush_data",     r1_out_data,      32'h300);
        flush   = 1'b1;
        in_data = 32'h302;
        #1;
        check("flush_in_ready0", 32'(r0_in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(r1_out_valid), 32'd0);
        check("flush_ctrl",  32'(r1_out_ctrl),  32'd0);
        check("flush_stale", r1_out_data,       32'h300);
        out_ready = 1'b1;
        tick();
        check("flush_k_gone",     32'(r1_out_valid), 32'd0);
        check("flush_in_ready1",  32'(r1_in_ready),  32'd1);

        // Asynchronous reset mid-operation, M+K full (SKID=1) and M full (SKID=0)
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h400;
        tick();
        in_data = 32'h401;
        tick();
        check("pre_rst_valid1",    32'(r1_out_valid), 32'd1);
        check("pre_rst_in_ready1", 32'(r1_in_ready),  32'd0);
        check("pre_rst_valid0",    32'(r0_out_valid), 32'd1);
        check("pre_rst_data0",     r0_out_data,       32'h400);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid1", 32'(r1_out_valid), 32'd0);
        check("arst_ctrl1",  32'(r1_out_ctrl),  32'd0);
        check("arst_data1",  r1_out_data,       32'd0);
        check("arst_valid0", 32'(r0_out_valid), 32'd0);
        check("arst_ctrl0",  32'(r0_out_ctrl),  32'd0);
        check("arst_ready1", 32'(r1_in_ready),  32'd1);
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
